mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the pipelined core's fetch stage (read-only) and memory stage (read/write).
- Serialises accesses against a variable-latency memory with a req/ack handshake.
- Returns read data to each requester and drives StallF/StallM so the hazard logic freezes the stalled stage.
- Sits between the core datapath and the memory inside top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, cycles in an access state with no MemAck before Err sets. Range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- IReq  in  1  fetch read request; held until IValid.
- IAdr  in  ADDR_W  fetch address.
- IRdata  out  DATA_W  fetched instruction; registered.
- IValid  out  1  one-cycle completion pulse for fetch.
- DReq  in  1  data request; held until DValid.
- DWe  in  1  1 = write, 0 = read.
- DAdr  in  ADDR_W  data address.
- DWdata  in  DATA_W  write data.
- DRdata  out  DATA_W  load data; registered.
- DValid  out  1  one-cycle completion pulse for data.
- MemReq  out  1  memory request; registered.
- MemWe  out  1  memory write enable; registered.
- MemAdr  out  ADDR_W  memory address; registered.
- MemWdata  out  DATA_W  memory write data; registered.
- MemRdata  in  DATA_W  memory read data; valid when MemAck=1.
- MemAck  in  1  memory completion, sampled on clk.
- StallF  out  1  IReq & ~IValid (combinational).
- StallM  out  1  DReq & ~DValid (combinational).
- Err  out  1  sticky timeout flag.

Behaviour:
- Reset (async): state IDLE; MemReq, MemWe, IValid, DValid, Err = 0; MemAdr, MemWdata, IRdata, DRdata = 0; wait counter = 0; lastD = 0.
- States: IDLE, DACC, IACC.
- IDLE eligibility:
  - D is eligible when DReq=1 and DValid=0.
  - I is eligible when IReq=1 and IValid=0.
  - This masking prevents re-granting a request that completes this cycle.
- IDLE grant, both eligible: grant D unless lastD=1, in which case grant I. This is anti-starvation alternation.
- IDLE grant, one eligible: grant it.
- IDLE grant, none eligible: stay in IDLE.
- On grant:
  - Register MemAdr and MemWe (DWe for D, 0 for I), plus MemWdata (D only).
  - Set MemReq=1 and lastD = (grant==D); clear the wait counter.
  - Go to DACC or IACC.
- DACC/IACC:
  - MemReq and MemAdr/MemWe/MemWdata are held stable.
  - Each cycle with MemAck=0 increments the wait counter, saturating.
  - When the counter reaches TIMEOUT, set Err (sticky until reset) and keep waiting.
- On a clock edge with MemAck=1:
  - MemReq goes to 0 and the state returns to IDLE.
  - Pulse IValid or DValid for exactly the next cycle.
  - For a read, capture MemRdata into IRdata/DRdata.
  - For a write, DRdata is unchanged.
- Minimum latency (cycles counted from the request cycle):
  - Cycle 0: request seen in IDLE.
  - Cycle 1: MemReq=1.
  - Cycle 2: Valid=1, provided MemAck=1 in cycle 1.
  - Total: 2 cycles per access; back-to-back grant possible in the Valid cycle.
- MemAck while in IDLE is ignored.
- IRdata/DRdata hold their value between completions.
- A requester dropping Req mid-access does not abort the access: it completes and Valid still pulses.
- An async reset mid-access abandons the transaction immediately: MemReq drops and no Valid is produced.
- StallF and StallM are purely combinational from IReq/DReq and the registered Valid signals. There are no loops through the Mem* inputs.

Test Plan:
- Lone fetch: IReq=1, IAdr=0x0; memory acks 1 cycle after MemReq with 0xE04F000F → MemAdr=0x0, MemWe=0; IValid pulses at cycle 2 with IRdata=0xE04F000F; StallF=1 in cycles 0-1 and 0 in cycle 2.
- Store: DReq=1, DWe=1, DAdr=100, DWdata=7 → MemReq/MemWe=1, MemAdr=100, MemWdata=7; DValid single pulse; DRdata unchanged.
- Contention: IReq and DReq both held from cycle 0, ack latency 1 → D granted first (MemAdr=DAdr), I granted in the DValid cycle; with continuous requests afterwards, grants alternate D, I, D, I.
- Slow memory: MemAck withheld 20 cycles with TIMEOUT=15 → Err=1 from wait count 15; MemReq stays 1 throughout; on ack, Valid pulses; Err stays 1 until reset.
- Reset mid-access: assert reset while in DACC → MemReq=0 immediately (async); no DValid; after release, a new DReq is granted normally with Err=0.
- Read data capture: load from DAdr=96 returning 0x12345678 → DRdata=0x12345678, held through a subsequent fetch completion.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported I/D memory between the fetch stage (read-only) and memory stage (read/write).
// Latency: 2 cycles minimum per access (grant -> MemReq, then Valid on the cycle after MemAck); back-to-back grants possible.
// Backpressure: each requester holds Req until its Valid pulse; StallF/StallM freeze the waiting pipeline stage.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAdr,
  output logic [DATA_W-1:0] IRdata,
  output logic              IValid,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAdr,
  input  logic [DATA_W-1:0] DWdata,
  output logic [DATA_W-1:0] DRdata,
  output logic              DValid,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAdr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic              MemAck,
  output logic              StallF,
  output logic              StallM,
  output logic              Err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              ivalid_q, ivalid_d;
  logic              dvalid_q, dvalid_d;
  logic              err_q, err_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              last_d_q, last_d_d;

  // A requester whose Valid is high this cycle has already been served; masking
  // it keeps the same held request from being granted a second time.
  logic i_elig, d_elig, grant_d;
  assign i_elig  = IReq & ~ivalid_q;
  assign d_elig  = DReq & ~dvalid_q;
  // D wins ties unless it won the previous grant, so fetch cannot starve.
  assign grant_d = d_elig & (~i_elig | ~last_d_q);

  // Next-state logic: grant in IDLE, hold the memory request until MemAck, track timeout.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    ivalid_d    = 1'b0;
    dvalid_d    = 1'b0;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
    last_d_d    = last_d_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = DACC;
          mem_req_d   = 1'b1;
          mem_we_d    = DWe;
          mem_adr_d   = DAdr;
          mem_wdata_d = DWdata;
          last_d_d    = 1'b1;
          wait_cnt_d  = 8'd0;
        end else if (i_elig) begin
          state_d    = IACC;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_adr_d  = IAdr;
          last_d_d   = 1'b0;
          wait_cnt_d = 8'd0;
        end
      end
      DACC, IACC: begin
        if (MemAck) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == IACC) begin
            ivalid_d = 1'b1;
            irdata_d = MemRdata;
          end else begin
            dvalid_d = 1'b1;
            if (!mem_we_q) begin
              drdata_d = MemRdata;
            end
          end
        end else begin
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
          // Err is only a warning: the access keeps waiting for its ack.
          if (wait_cnt_d >= TIMEOUT_C) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State registers; async reset abandons any in-flight access without a Valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt_q  <= 8'd0;
      last_d_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      ivalid_q    <= ivalid_d;
      dvalid_q    <= dvalid_d;
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
      last_d_q    <= last_d_d;
    end
  end

  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAdr   = mem_adr_q;
  assign MemWdata = mem_wdata_q;
  assign IRdata   = irdata_q;
  assign DRdata   = drdata_q;
  assign IValid   = ivalid_q;
  assign DValid   = dvalid_q;
  assign Err      = err_q;

  // Stalls depend only on requester inputs and registered Valids, never on Mem* inputs.
  assign StallF = IReq & ~ivalid_q;
  assign StallM = DReq & ~dvalid_q;

endmodule
